// File: rtl/mem_xfer_seq.sv
// mem_xfer_seq: sequences one load/store request into one or two 32-bit memory words; optional watchdog via SEQ_TIMEOUT_EN
module mem_xfer_seq #(
  parameter int TIMEOUT = 15
) (
  input  logic Clk,
  input  logic Reset,
  input  logic start,
  input  logic op_wr,
  input  logic op_dbl,
  input  logic op_fp,
  input  logic op_stk,
  input  logic mem_rdy,
  output logic dMem_cs,
  output logic dMem_rd,
  output logic dMem_wr,
  output logic dMem_addr_sel,
  output logic RdBuf1_ld,
  output logic RdBuf0_ld,
  output logic WrBuf1_oe,
  output logic WrBuf0_oe,
  output logic FP1_oe,
  output logic FP0_oe,
  output logic MAR_inc,
  output logic SP_inc,
  output logic SP_dec,
  output logic busy,
  output logic done,
  output logic err
);
  typedef enum logic [1:0] {IDLE, ACCESS, ADVANCE, DONE} state_t;
  state_t state, nxt;
  logic wr, fp, stk, hi, rd1_en, rd0_en, tmo;
  logic n_wr, n_fp, n_stk, n_hi, acc, adv;
`ifdef SEQ_TIMEOUT_EN
  logic [7:0] cnt;
`endif
  // next state, next latched operands and the Moore decode of the next state
  always_comb begin
`ifdef SEQ_TIMEOUT_EN
    tmo = state == ACCESS && !mem_rdy && cnt == 8'(TIMEOUT);
`else
    tmo = 1'b0;
`endif
    nxt = state == IDLE ? (start ? ACCESS : IDLE) :
          state == ACCESS ? (mem_rdy ? ADVANCE : tmo ? DONE : ACCESS) :
          state == ADVANCE ? (hi ? ACCESS : DONE) : IDLE;
    n_wr = state == IDLE ? op_wr : wr;
    n_fp = state == IDLE ? op_fp : fp;
    n_stk = state == IDLE ? op_stk : stk;
    n_hi = state == IDLE ? op_dbl : state == ADVANCE ? 1'b0 : hi;
    acc = nxt == ACCESS;
    adv = nxt == ADVANCE;
  end
  // state, operand latches and registered outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      {wr, fp, stk, hi, rd1_en, rd0_en} <= '0;
      {dMem_cs, dMem_rd, dMem_wr, dMem_addr_sel} <= '0;
      {WrBuf1_oe, WrBuf0_oe, FP1_oe, FP0_oe} <= '0;
      {MAR_inc, SP_inc, SP_dec, busy, done} <= '0;
    end else begin
      state <= nxt;
      wr <= n_wr;
      fp <= n_fp;
      stk <= n_stk;
      hi <= n_hi;
      dMem_cs <= acc;
      dMem_rd <= acc && !n_wr;
      dMem_wr <= acc && n_wr;
      dMem_addr_sel <= nxt != IDLE && n_stk;
      rd1_en <= acc && !n_wr && n_hi;
      rd0_en <= acc && !n_wr && !n_hi;
      WrBuf1_oe <= acc && n_wr && !n_fp && n_hi;
      WrBuf0_oe <= acc && n_wr && !n_fp && !n_hi;
      FP1_oe <= acc && n_wr && n_fp && n_hi;
      FP0_oe <= acc && n_wr && n_fp && !n_hi;
      MAR_inc <= adv && !n_stk;
      SP_dec <= adv && n_stk && n_wr;
      SP_inc <= adv && n_stk && !n_wr;
      busy <= nxt != IDLE;
      done <= nxt == DONE;
    end
  end
`ifdef SEQ_TIMEOUT_EN
  // watchdog: clears on ACCESS entry, counts wait cycles, flags the abort
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= (nxt == ACCESS && state != ACCESS) ? 8'd0 : (state == ACCESS && !mem_rdy) ? cnt + 8'd1 : cnt;
      err <= tmo;
    end
  end
`else
  assign err = 1'b0;
`endif
  assign RdBuf1_ld = rd1_en && mem_rdy;
  assign RdBuf0_ld = rd0_en && mem_rdy;
endmodule

// File: doc/mem_xfer_seq.md
# mem_xfer_seq

Data-memory transfer sequencer. It sits directly upstream of the bus interface unit and drives the BIU's per-word strobes, address-advance pulses and the data-memory control lines. It turns one load/store request from the control unit into one or two 32-bit memory cycles on the shared 32-bit data bus. It handles a memory-ready handshake with wait states and includes an optional watchdog.

## Interface
- TIMEOUT, 15: maximum cycles to wait for `mem_rdy` in one access (1–255); used only with the watchdog.
- Clk  in  1  rising-edge clock; the only clock.
- Reset  in  1  synchronous, active-high reset.
- start  in  1  request strobe; sampled only in IDLE.
- op_wr  in  1  1 = store, 0 = load.
- op_dbl  in  1  1 = 64-bit transfer (two words), 0 = 32-bit transfer (low word only).
- op_fp  in  1  store source: 1 = FP buffers, 0 = integer write buffers. Ignored for loads.
- op_stk  in  1  1 = stack access (address from SP), 0 = MAR access.
- mem_rdy  in  1  memory completes the current word in this cycle.
- dMem_cs, dMem_rd, dMem_wr  out  1 each  memory chip select, read and write.
- dMem_addr_sel  out  1  address source select to the BIU (the latched op_stk).
- RdBuf1_ld, RdBuf0_ld  out  1 each  capture the bus into the high or low read buffer.
- WrBuf1_oe, WrBuf0_oe, FP1_oe, FP0_oe  out  1 each  drive the high or low store word onto the bus.
- MAR_inc, SP_inc, SP_dec  out  1 each  address-advance pulses.
- busy  out  1  high from the cycle after start is accepted until DONE, inclusive.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle timeout pulse; always coincident with done.

## Operation
- States: IDLE, ACCESS, ADVANCE, DONE.
  - IDLE→ACCESS on start. The block latches op_wr, op_dbl, op_fp and op_stk, and sets word = HI if op_dbl is 1, otherwise LO.
  - ACCESS→ADVANCE when mem_rdy = 1.
  - ADVANCE→ACCESS with word = LO if the word just completed was HI.
  - ADVANCE→DONE if the word just completed was LO.
  - DONE→IDLE unconditionally.
- Word order is always the high word first, then the low word.
- ACCESS outputs:
  - dMem_cs = 1 throughout.
  - dMem_rd = ~op_wr and dMem_wr = op_wr, held throughout.
  - Store: the selected oe pair's HI/LO member is held high for the whole state; the source (WrBuf or FP) is chosen by op_fp.
  - Load: RdBuf1_ld (HI) or RdBuf0_ld (LO) is high only in the cycle where mem_rdy = 1.
- ADVANCE outputs: exactly one one-cycle pulse.
  - MAR_inc when op_stk = 0.
  - SP_dec for a stack store (push).
  - SP_inc for a stack load (pop).
  - Memory strobes are 0 in this state.
- dMem_addr_sel = the latched op_stk while busy, and 0 in IDLE.
- A start received while busy is ignored and not queued.
- Operand inputs are don't-care after the start cycle.
- Only one of the oe and ld outputs is ever high in any cycle; a bench check must confirm this.

## Timing
- Reset: every output is 0, state = IDLE, watchdog counter = 0. Reset asserted mid-transfer aborts the transfer at the next edge with no done pulse; any pointer pulse already issued is not undone.
- All outputs are registered/Moore, except the RdBuf*_ld outputs, which are the combinational AND of mem_rdy and the load access.
- Zero-wait latency, counted from the edge that samples start to the DONE cycle: 5 cycles for op_dbl = 1, 3 cycles for op_dbl = 0. Each wait cycle (mem_rdy = 0 during ACCESS) adds 1 cycle.
- mem_rdy is ignored outside ACCESS.
- A new start may be sampled in the cycle after DONE, so the back-to-back issue rate is one request per 6 cycles for double-word transfers.

## Configuration
- SEQ_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to ACCESS and increments on each cycle in ACCESS with mem_rdy = 0.
  - When the counter equals TIMEOUT while mem_rdy is still 0, the next state is DONE with err = 1 and done = 1.
  - A timeout skips ADVANCE (no pointer pulse for the failed word) and abandons any remaining word.
  - mem_rdy arriving in the same cycle the counter reaches TIMEOUT counts as success.
- SEQ_TIMEOUT_EN undefined: no counter, ACCESS waits indefinitely, and err is tied to 0.

## Test plan
- 64-bit MAR load, mem_rdy held at 1:
  - RdBuf1_ld high in cycle 1 and RdBuf0_ld high in cycle 3.
  - MAR_inc pulses in cycles 2 and 4.
  - done in cycle 5, busy high for cycles 1–5.
  - Bus values 0xDEADBEEF (HI) and 0x01234567 (LO) are captured in that order.
- 32-bit stack store (op_stk = 1, op_wr = 1, op_fp = 0) with 3 wait cycles:
  - WrBuf0_oe and dMem_wr are high for 4 cycles.
  - dMem_addr_sel = 1 while busy.
  - A single SP_dec pulse, then done at cycle 6.
- 64-bit FP store:
  - FP1_oe is active during the first ACCESS and FP0_oe during the second.
  - WrBuf*_oe is never high.
  - start pulsed mid-transfer causes no extra transfer.
- Stack 64-bit load (pop): SP_inc pulses twice and MAR_inc never pulses.
- SEQ_TIMEOUT_EN with TIMEOUT = 4 and mem_rdy held at 0:
  - err and done pulse together 6 cycles after the start sample.
  - No MAR_inc pulse, then IDLE.
  - Without the macro, busy stays high indefinitely.
- Reset asserted during the second ACCESS of a 64-bit load: all outputs are 0 at the next edge, no done pulse, and the next start transfers normally.
